mux_nne1_arb: RTL
=================

# mux_nne1_arb

Parametrised N-to-1, W-bit registered multiplexer with valid/ready handshake. It is the successor of the CPU's 2:1 select mux. Channel choice is either fixed by an external select or made by an internal round-robin arbiter, and the winner is captured in a single-entry output register. It sits in the datapath wherever several producers share one bus, for example ALU/memory/immediate write-back to the register file, or multiple requesters to the memory port.

## Interface
- W, default 16: data width per channel.
- N, default 4: channel count; N ≥ 2.
- SW, default $clog2(N): select/index width (derived, do not override).

- Clock  input  1: single clock, rising edge.
- Reset  input  1: synchronous, active-high.
- hyrja  input  N*W: channel data; channel i at bits [i*W +: W].
- hyrja_valid  input  N: channel i offers data.
- hyrja_gati  output  N: channel i accepted this cycle (ready).
- Sinjali  input  SW: channel select, used in fixed mode only.
- Modi  input  1: 0 = fixed select, 1 = round-robin.
- dalja  output  W: registered output data.
- dalja_valid  output  1: dalja holds valid data.
- dalja_ready  input  1: consumer accepts dalja this cycle.
- zgjedhja  output  SW: index of the channel whose data is in dalja.

## Operation
- Reset is synchronous and active-high. While Reset=1, all of the following hold: dalja=0, dalja_valid=0, zgjedhja=0, RR pointer=0, hyrja_gati=0.
- accept = !dalja_valid || dalja_ready. The output register can load this cycle.
- Fixed mode (Modi=0):
  - grant channel g = Sinjali.
  - hyrja_gati[g] = accept. This does not depend on hyrja_valid[g].
  - A load occurs only if hyrja_valid[g]=1.
  - If Sinjali ≥ N, there is no grant and no load.
- Round-robin mode (Modi=1):
  - Among the valid channels, grant the first one at index ≥ ptr, wrapping modulo N.
  - hyrja_gati[g] = accept && any valid.
  - Only one hyrja_gati bit is ever high.
- Transfer on channel g occurs when hyrja_valid[g] && hyrja_gati[g]. On the next edge:
  - dalja ← hyrja[g], zgjedhja ← g, dalja_valid ← 1.
  - In RR mode only: ptr ← (g+1) mod N.
- The pointer never advances without a transfer. The pointer holds in fixed mode and is not cleared by mode changes.
- When dalja_valid && dalja_ready and there is no new transfer, dalja_valid ← 0. dalja and zgjedhja hold their last values.
- Simultaneous drain and load: the register takes the new data and dalja_valid stays 1. Full throughput is one word per cycle.
- Stall (dalja_valid && !dalja_ready): every hyrja_gati is 0, and dalja, dalja_valid and zgjedhja are stable.
- Modi and Sinjali are sampled every cycle. A change takes effect on the same cycle's grant and never corrupts data already held.

## Timing
- Latency: input transfer at edge k, data on dalja after edge k.
- hyrja_gati is combinational from dalja_valid, dalja_ready, Modi, Sinjali and (in RR mode) hyrja_valid. There is no combinational path from hyrja to dalja.
- Fairness: with all N channels continuously valid and dalja_ready=1, each channel is granted exactly once every N cycles.
- Reset asserted mid-transfer: the held word is discarded and dalja_valid=0 on the edge after Reset is sampled high.

## Structure
- Shared package mux_pkg holds the mode constants: MODI_FIKS = 1'b0 and MODI_RR = 1'b1.
- Sub-module rr_arbiter is parametrised on N and is purely combinational.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, encoded index, any-grant.
- The top level holds the output register, the pointer register and the handshake logic.

## Test plan
- Reset: assert Reset for 2 cycles with all inputs valid. Required: dalja=0, dalja_valid=0, hyrja_gati=0 throughout. After release, the first RR grant goes to channel 0.
- Fixed mode: N=4, Modi=0, Sinjali=2, hyrja ch2=16'hBEEF with valid, dalja_ready=1. Required: gati=4'b0100 and, one cycle later, dalja=16'hBEEF, zgjedhja=2. With Sinjali=2 and ch2 invalid: no load and dalja_valid falls.
- RR fairness: all 4 channels valid with data 16'h000i. Required: zgjedhja sequence 0,1,2,3,0,… and dalja_valid continuously 1.
- RR skip and wrap: ptr=3 and only channels 1 and 3 valid. Required: grant 3, then 1, then 3.
- Backpressure: hold dalja_ready=0 for 3 cycles while data is held. Required: gati=0, dalja stable, ptr unchanged. Releasing dalja_ready gives a simultaneous drain and load with no bubble.
- Mode switch mid-stream: go from RR (ptr=2) to fixed with Sinjali=0, then back to RR. Required: in fixed mode ch0 is granted each cycle. On return to RR, arbitration resumes from ptr=2.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the N-to-1 registered mux and its arbiter.
package mux_pkg;
    localparam logic MODI_FIKS = 1'b0;
    localparam logic MODI_RR   = 1'b1;
endpackage

// File: rtl/mux_nne1_arb_if.sv
// Producer/consumer bundle around the N-to-1 registered mux.
interface mux_nne1_arb_if #(
    parameter int W = 16,
    parameter int N = 4
);
    localparam int SW = $clog2(N);

    logic [N*W-1:0] hyrja;
    logic [N-1:0]   hyrja_valid;
    logic [N-1:0]   hyrja_gati;
    logic [SW-1:0]  Sinjali;
    logic           Modi;
    logic [W-1:0]   dalja;
    logic           dalja_valid;
    logic           dalja_ready;
    logic [SW-1:0]  zgjedhja;

    modport master (
        output hyrja, hyrja_valid, Sinjali, Modi, dalja_ready,
        input  hyrja_gati, dalja, dalja_valid, zgjedhja
    );

    modport slave (
        input  hyrja, hyrja_valid, Sinjali, Modi, dalja_ready,
        output hyrja_gati, dalja, dalja_valid, zgjedhja
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 4,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] idx,
    output logic          any_gnt
);
    int  c;
    logic found;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        found   = 1'b0;
        c       = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = SW'(c);
            end
        end
        any_gnt = |req;
    end
endmodule

// File: rtl/mux_nne1_arb.sv
// N-to-1 registered mux with valid/ready handshake; channel picked by
// external select (fixed mode) or by the round-robin arbiter.
module mux_nne1_arb #(
    parameter int W = 16,
    parameter int N = 4,
    localparam int SW = $clog2(N)
) (
    input  logic              Clock,
    input  logic              Reset,
    mux_nne1_arb_if.slave     bus
);
    import mux_pkg::*;

    logic [W-1:0]  dalja_q, dalja_d;
    logic          dalja_valid_q, dalja_valid_d;
    logic [SW-1:0] zgjedhja_q, zgjedhja_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic [N-1:0]  rr_gnt;
    logic [SW-1:0] rr_idx;
    logic          rr_any;

    logic          accept;
    logic          sel_ok;
    logic          load;
    logic [SW-1:0] g;
    logic [N-1:0]  gati;

    rr_arbiter #(.N(N)) u_arb (
        .req     (bus.hyrja_valid),
        .ptr     (ptr_q),
        .gnt     (rr_gnt),
        .idx     (rr_idx),
        .any_gnt (rr_any)
    );

    // Grant depends only on handshake state and select inputs, never on hyrja.
    always_comb begin
        accept = !dalja_valid_q || bus.dalja_ready;
        sel_ok = int'(bus.Sinjali) < N;
        gati   = '0;
        g      = '0;
        load   = 1'b0;
        if (!Reset) begin
            if (bus.Modi == MODI_RR) begin
                g = rr_idx;
                if (accept && rr_any) begin
                    gati = rr_gnt;
                    load = 1'b1;
                end
            end else begin
                g = bus.Sinjali;
                if (sel_ok && accept) begin
                    gati[g] = 1'b1;
                    load    = bus.hyrja_valid[g];
                end
            end
        end
    end

    always_comb begin
        dalja_d       = dalja_q;
        dalja_valid_d = dalja_valid_q;
        zgjedhja_d    = zgjedhja_q;
        ptr_d         = ptr_q;
        if (load) begin
            dalja_d       = bus.hyrja[int'(g)*W +: W];
            zgjedhja_d    = g;
            dalja_valid_d = 1'b1;
            if (bus.Modi == MODI_RR) begin
                ptr_d = (int'(g) == N - 1) ? '0 : g + SW'(1);
            end
        end else if (dalja_valid_q && bus.dalja_ready) begin
            dalja_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            dalja_q       <= '0;
            dalja_valid_q <= 1'b0;
            zgjedhja_q    <= '0;
            ptr_q         <= '0;
        end else begin
            dalja_q       <= dalja_d;
            dalja_valid_q <= dalja_valid_d;
            zgjedhja_q    <= zgjedhja_d;
            ptr_q         <= ptr_d;
        end
    end

    assign bus.hyrja_gati  = gati;
    assign bus.dalja       = dalja_q;
    assign bus.dalja_valid = dalja_valid_q;
    assign bus.zgjedhja    = zgjedhja_q;
endmodule
